// File: rtl/irrig_sched_if.sv
// Zone request/duration inputs and valve/status outputs of irrig_sched.
// Rain exists only when RAIN_INHIBIT_EN is defined.
interface irrig_sched_if;
    logic [3:0] Req;
    logic [3:0] D0;
    logic [3:0] D1;
    logic [3:0] D2;
    logic [3:0] D3;
`ifdef RAIN_INHIBIT_EN
    logic       Rain;
`endif
    logic [3:0] Grant;
    logic [3:0] Valve;
    logic [1:0] Zone;
    logic [3:0] Cnt;
    logic       Busy;
    logic       Done;

    modport master (
`ifdef RAIN_INHIBIT_EN
        output Rain,
`endif
        output Req, D0, D1, D2, D3,
        input  Grant, Valve, Zone, Cnt, Busy, Done
    );

    modport slave (
`ifdef RAIN_INHIBIT_EN
        input  Rain,
`endif
        input  Req, D0, D1, D2, D3,
        output Grant, Valve, Zone, Cnt, Busy, Done
    );
endinterface

// File: rtl/irrig_sched.sv
// Four-zone irrigation sequencer: rotating grant, one shared run timer.
// Define RAIN_INHIBIT_EN to add a Rain input that holds off grants and pauses runs.
module irrig_sched #(
    parameter int GAP_CYC = 2
) (
    input logic          Ck,
    input logic          Clr,
    irrig_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, GAP} state_t;

    localparam int         GAP_LD_I = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam logic [3:0] GAP_LD   = 4'(GAP_LD_I);
    localparam bit         GAP_SKIP = (GAP_CYC == 0);
    localparam state_t     POST     = GAP_SKIP ? IDLE : GAP;

    state_t     state_q;
    logic [1:0] ptr_q;
    logic [1:0] zone_q;
    logic [3:0] grant_q;
    logic [3:0] valve_q;
    logic [3:0] cnt_q;
    logic [3:0] gap_q;
    logic       busy_q;
    logic       done_q;

    logic [1:0] sel_d;
    logic       found_d;
    logic [3:0] dur_d;
    logic       rain_w;

`ifdef RAIN_INHIBIT_EN
    assign rain_w = bus.Rain;
`else
    assign rain_w = 1'b0;
`endif

    // Scan from the highest offset down so the nearest set bit after ptr wins.
    always_comb begin
        sel_d   = ptr_q;
        found_d = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.Req[ptr_q + 2'(k)]) begin
                sel_d   = ptr_q + 2'(k);
                found_d = 1'b1;
            end
        end
    end

    always_comb begin
        dur_d = bus.D0;
        unique case (zone_q)
            2'd0: dur_d = bus.D0;
            2'd1: dur_d = bus.D1;
            2'd2: dur_d = bus.D2;
            2'd3: dur_d = bus.D3;
        endcase
    end

    always_ff @(posedge Ck or negedge Clr) begin
        if (!Clr) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            zone_q  <= 2'd0;
            grant_q <= 4'd0;
            valve_q <= 4'd0;
            cnt_q   <= 4'd0;
            gap_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (found_d && !rain_w) begin
                        state_q <= LOAD;
                        zone_q  <= sel_d;
                        ptr_q   <= sel_d + 2'd1;
                        grant_q <= 4'd1 << sel_d;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!bus.Req[zone_q]) begin
                        cnt_q   <= 4'd0;
                        state_q <= POST;
                        gap_q   <= GAP_LD;
                        if (GAP_SKIP) begin
                            grant_q <= 4'd0;
                            busy_q  <= 1'b0;
                        end
                    end else if (dur_d == 4'd0) begin
                        cnt_q   <= 4'd0;
                        state_q <= IDLE;
                        grant_q <= 4'd0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= dur_d;
                        valve_q <= grant_q;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.Req[zone_q]) begin
                        cnt_q   <= 4'd0;
                        valve_q <= 4'd0;
                        state_q <= POST;
                        gap_q   <= GAP_LD;
                        if (GAP_SKIP) begin
                            grant_q <= 4'd0;
                            busy_q  <= 1'b0;
                        end
                    end else if (rain_w) begin
                        valve_q <= 4'd0;
                    end else if (cnt_q <= 4'd1) begin
                        cnt_q   <= 4'd0;
                        valve_q <= 4'd0;
                        done_q  <= 1'b1;
                        state_q <= POST;
                        gap_q   <= GAP_LD;
                        if (GAP_SKIP) begin
                            grant_q <= 4'd0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q   <= cnt_q - 4'd1;
                        valve_q <= grant_q;
                    end
                end
                GAP: begin
                    if (gap_q == 4'd0) begin
                        state_q <= IDLE;
                        grant_q <= 4'd0;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
            endcase
        end
    end

    assign bus.Grant = grant_q;
    assign bus.Valve = valve_q;
    assign bus.Zone  = zone_q;
    assign bus.Cnt   = cnt_q;
    assign bus.Busy  = busy_q;
    assign bus.Done  = done_q;
endmodule

// File: doc/irrig_sched.md
IRRIG_SCHED -- requirements
Module: irrig_sched

Interface
REQ-001 Parameter GAP_CYC, default 2, closed-valve settle cycles after each zone run (legal 0..15).
REQ-002 Ck  input  1  system clock; all state updates on the rising edge.
REQ-003 Clr  input  1  reset, asynchronous and active-low; the clock is named Ck and the reset is named Clr, polarity and synchronicity are fixed.
REQ-004 Req  input  4  per-zone irrigation request (zone i = bit i), level-sensitive.
REQ-005 D0, D1, D2, D3  input  4 each  per-zone run duration in cycles, sampled in LOAD.
REQ-006 Rain  input  1  rain inhibit, present only when RAIN_INHIBIT_EN is defined.
REQ-007 Grant  output  4  one-hot, zone currently owning the shared timer; 0 in IDLE.
REQ-008 Valve  output  4  one-hot valve drive, only the granted zone, only in RUN.
REQ-009 Zone  output  2  index of the granted zone.
REQ-010 Cnt  output  4  remaining run cycles.
REQ-011 Busy  output  1  high in any state except IDLE.
REQ-012 Done  output  1  one-cycle pulse on normal completion of a run.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, RUN, GAP; all outputs SHALL be registered.
REQ-014 IDLE: if Req != 0, select the first set bit scanning Ptr, Ptr+1, ... mod 4; latch Zone; go to LOAD; set Ptr <= selected+1 mod 4.
REQ-015 LOAD (1 cycle): Grant = one-hot(Zone); Cnt <= D[Zone]; D[Zone]=0 -> back to IDLE with no valve and no Done; otherwise -> RUN.
REQ-016 RUN: Valve[Zone]=1; Cnt decrements by 1 per cycle; the valve SHALL be open exactly D[Zone] cycles.
REQ-017 On the RUN cycle with Cnt==1: next state GAP, Cnt <= 0, Done=1 for exactly that next cycle.
REQ-018 Req[Zone]=0 sampled in LOAD or RUN: abort; Valve <= 0 next cycle, Cnt <= 0, go to GAP, no Done.
REQ-019 Requests from other zones during LOAD/RUN/GAP SHALL be ignored until IDLE (no preemption).
REQ-020 GAP: Valve = 0, Grant held; stay GAP_CYC cycles, then IDLE, Grant <= 0; GAP_CYC=0 -> one GAP cycle is skipped entirely (RUN/abort -> IDLE directly).
REQ-021 Cnt SHALL never wrap below 0; Valve SHALL never have more than one bit set.

Reset
REQ-022 Clr=0 at any time, mid-run included, SHALL asynchronously force: state IDLE, Ptr=0, Zone=0, Grant=0, Valve=0, Cnt=0, Busy=0, Done=0, gap counter=0.
REQ-023 After Clr release, the first grant SHALL follow REQ-014 with Ptr=0 (zone 0 highest priority).

Configuration
REQ-024 Macro RAIN_INHIBIT_EN defined: Rain port exists; Rain=1 in IDLE blocks new grants; Rain=1 in RUN forces Valve=0 and freezes Cnt, resuming when Rain=0; GAP unaffected.
REQ-025 Macro RAIN_INHIBIT_EN undefined: no Rain port; behaviour exactly as REQ-013..REQ-021.

Verification
REQ-026 Clr pulse, Req=0001, D0=3, GAP_CYC=2 -> Grant=0001 one cycle before Valve=0001 for exactly 3 cycles, Cnt 3,2,1, Done pulse, 2 GAP cycles, IDLE.
REQ-027 Req=1111 held, all D=2 -> zones served in order 0,1,2,3,0; never two Valve bits set.
REQ-028 Req=0100, D2=0 -> LOAD then IDLE, Valve stays 0000, no Done, Ptr=3.
REQ-029 Req=0010, D1=8, drop Req[1] after 3 RUN cycles -> Valve=0000 next cycle, no Done, GAP then IDLE.
REQ-030 Clr low at RUN with Cnt=5 -> all outputs 0 immediately without a clock edge; Req=1000 after release -> zone 3 granted.
REQ-031 With RAIN_INHIBIT_EN, D0=4, Rain=1 for 3 cycles mid-RUN -> Valve closed and Cnt frozen for those 3 cycles; total open time still 4 cycles.
